// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates the fetch and data ports onto one split addr/data SRAM-style bus, with one transaction outstanding.
// Latency: a request seen in IDLE drives req on the next cycle; addr_ok and data_ok are forwarded to the owner combinationally.
// Backpressure: the owner stalls on its addr_ok/data_ok, and the other port is not sampled until the bus is back in IDLE.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        req,
   output logic        wr,
   output logic [1:0]  size,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic        addr_ok,
   input  logic        data_ok,
   input  logic [31:0] rdata,
   output logic        busy
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   state_t         state_q, state_d;
   logic           owner_q;
   logic [SW-1:0]  streak_q;
   mem_req_t       ds_q;
   logic           inst_wins;
   logic           grant_inst;
   logic           grant_data;
   logic           addr_hit;
   logic           done;

   // Data normally wins; a waiting fetch takes over once the data streak hits the limit.
   always_comb begin
      inst_wins  = inst_req && (!data_req || (streak_q == SW'(STARVE_LIMIT)));
      grant_inst = (state_q == IDLE) && inst_wins;
      grant_data = (state_q == IDLE) && data_req && !inst_wins;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (inst_req || data_req) state_d = ADDR;
         ADDR:    if (addr_ok) state_d = data_ok ? IDLE : WAIT;
         WAIT:    if (data_ok) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      addr_hit     = (state_q == ADDR) && addr_ok;
      done         = (addr_hit && data_ok) || ((state_q == WAIT) && data_ok);
      req          = (state_q == ADDR);
      busy         = (state_q != IDLE);
      inst_addr_ok = addr_hit && !owner_q;
      data_addr_ok = addr_hit && owner_q;
      inst_data_ok = done && !owner_q;
      data_data_ok = done && owner_q;
   end

   // Request fields are captured at grant so the bus stays stable while the port moves on.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner_q  <= 1'b0;
         streak_q <= '0;
         ds_q     <= '0;
      end else if (grant_inst) begin
         owner_q  <= 1'b0;
         streak_q <= '0;
         ds_q     <= '{wr: 1'b0, size: 2'd2, addr: inst_addr, wdata: 32'd0};
      end else if (grant_data) begin
         owner_q <= 1'b1;
         ds_q    <= '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
         if (inst_req && (streak_q != SW'(STARVE_LIMIT))) begin
            streak_q <= streak_q + SW'(1);
         end
      end
   end

   assign wr         = ds_q.wr;
   assign size       = ds_q.size;
   assign addr       = ds_q.addr;
   assign wdata      = ds_q.wdata;
   assign inst_rdata = rdata;
   assign data_rdata = rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a grant-order model.
// Inputs change 1ns after the rising edge and outputs are sampled 2ns after it.
module tb_mem_port_arbiter;

   localparam int LIMIT = 4;
   localparam int SW    = $clog2(LIMIT + 1);

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_addr_ok, inst_data_ok;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_req, data_wr, data_addr_ok, data_data_ok;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        req, wr, addr_ok, data_ok, busy;
   logic [1:0]  size;
   logic [31:0] addr, wdata, rdata;

   int n_cmp  = 0;
   int n_fail = 0;
   int cnt    = 0;   // data grants taken while a fetch was waiting, since the last fetch grant

   mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata),
      .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
      .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      inst_req = 0; inst_addr = 0;
      data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
      addr_ok = 0; data_ok = 0; rdata = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      resetn = 0;
      inst_req = 1; data_req = 1; addr_ok = 1; data_ok = 1;
      #2;
      step();
      n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", req); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if ({wr, size, addr, wdata} !== 67'd0) begin n_fail++;
         $display("FAIL reset_fields: got %h want 0", {wr, size, addr, wdata}); end
      n_cmp++; if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0000) begin n_fail++;
         $display("FAIL reset_oks: got %b want 0000", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}); end
      n_cmp++; if (dut.streak_q !== SW'(0)) begin n_fail++; $display("FAIL reset_streak: got %0d want 0", dut.streak_q); end
      clear_inputs();
      step();
      resetn = 1;
      cnt = 0;
      step();
   endtask

   task automatic test_single_fetch();
      inst_req = 1; inst_addr = 32'hBFC0_0000;
      #1;
      n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL fetch_req_n: got %b want 0", req); end
      step();
      addr_ok = 1;
      #1;
      n_cmp++; if (req !== 1'b1) begin n_fail++; $display("FAIL fetch_req_n1: got %b want 1", req); end
      n_cmp++; if ({wr, size, addr, wdata} !== {1'b0, 2'd2, 32'hBFC0_0000, 32'd0}) begin n_fail++;
         $display("FAIL fetch_fields: got %h want %h", {wr, size, addr, wdata}, {1'b0, 2'd2, 32'hBFC0_0000, 32'd0}); end
      n_cmp++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_fail++;
         $display("FAIL fetch_addr_ok: got %b want 10", {inst_addr_ok, data_addr_ok}); end
      step();
      addr_ok = 0; inst_req = 0;
      #1;
      n_cmp++; if ({req, busy, inst_data_ok} !== 3'b010) begin n_fail++;
         $display("FAIL fetch_wait: got %b want 010", {req, busy, inst_data_ok}); end
      step();
      data_ok = 1; rdata = 32'h2408_0001;
      #1;
      n_cmp++; if ({inst_data_ok, data_data_ok, data_addr_ok} !== 3'b100) begin n_fail++;
         $display("FAIL fetch_data_ok: got %b want 100", {inst_data_ok, data_data_ok, data_addr_ok}); end
      n_cmp++; if (inst_rdata !== 32'h2408_0001) begin n_fail++;
         $display("FAIL fetch_rdata: got %h want 24080001", inst_rdata); end
      step();
      data_ok = 0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fetch_idle: got %b want 0", busy); end
      cnt = 0;
   endtask

   task automatic test_store();
      data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h8000_0013; data_wdata = 32'hAB;
      step();
      addr_ok = 1;
      #1;
      n_cmp++; if ({req, wr, size, addr, wdata} !== {1'b1, 1'b1, 2'd0, 32'h8000_0013, 32'hAB}) begin n_fail++;
         $display("FAIL store_fields: got %h want %h", {req, wr, size, addr, wdata},
                  {1'b1, 1'b1, 2'd0, 32'h8000_0013, 32'hAB}); end
      n_cmp++; if ({data_addr_ok, inst_addr_ok, inst_data_ok} !== 3'b100) begin n_fail++;
         $display("FAIL store_addr_ok: got %b want 100", {data_addr_ok, inst_addr_ok, inst_data_ok}); end
      step();
      addr_ok = 0; data_req = 0;
      step();
      data_ok = 1;
      #1;
      n_cmp++; if ({data_data_ok, inst_data_ok, inst_addr_ok} !== 3'b100) begin n_fail++;
         $display("FAIL store_data_ok: got %b want 100", {data_data_ok, inst_data_ok, inst_addr_ok}); end
      step();
      clear_inputs();
   endtask

   task automatic test_simultaneous();
      inst_req = 1; inst_addr = 32'hBFC0_0010;
      data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h8000_1000; data_wdata = 0;
      step();
      addr_ok = 1;
      #1;
      n_cmp++; if ({data_addr_ok, addr} !== {1'b1, 32'h8000_1000}) begin n_fail++;
         $display("FAIL simul_first: got %h want %h", {data_addr_ok, addr}, {1'b1, 32'h8000_1000}); end
      n_cmp++; if (dut.streak_q !== SW'(1)) begin n_fail++; $display("FAIL simul_streak1: got %0d want 1", dut.streak_q); end
      step();
      addr_ok = 0; data_req = 0;
      step();
      data_ok = 1; rdata = 32'h1234_5678;
      #1;
      n_cmp++; if ({data_data_ok, data_rdata} !== {1'b1, 32'h1234_5678}) begin n_fail++;
         $display("FAIL simul_data_ok: got %h want %h", {data_data_ok, data_rdata}, {1'b1, 32'h1234_5678}); end
      step();
      data_ok = 0;
      #1;
      n_cmp++; if ({req, busy} !== 2'b00) begin n_fail++; $display("FAIL simul_k1: got %b want 00", {req, busy}); end
      step();
      addr_ok = 1; data_ok = 1;
      #1;
      n_cmp++; if ({req, addr, inst_addr_ok, inst_data_ok} !== {1'b1, 32'hBFC0_0010, 2'b11}) begin n_fail++;
         $display("FAIL simul_k2: got %h want %h", {req, addr, inst_addr_ok, inst_data_ok}, {1'b1, 32'hBFC0_0010, 2'b11}); end
      n_cmp++; if (dut.streak_q !== SW'(0)) begin n_fail++; $display("FAIL simul_streak0: got %0d want 0", dut.streak_q); end
      step();
      clear_inputs();
      cnt = 0;
   endtask

   task automatic test_starvation();
      logic exp_inst;
      inst_req = 1; inst_addr = 32'hBFC0_0100;
      data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h8000_2000;
      for (int g = 0; g < 12; g++) begin
         // With a fetch always waiting, every LIMIT data grants are followed by one fetch grant.
         exp_inst = (cnt == LIMIT);
         cnt = exp_inst ? 0 : cnt + 1;
         step();
         addr_ok = 1; data_ok = 1; rdata = $urandom;
         #1;
         n_cmp++; if (addr !== (exp_inst ? inst_addr : data_addr)) begin n_fail++;
            $display("FAIL starve_grant%0d: got addr %h want %s", g, addr, exp_inst ? "inst" : "data"); end
         n_cmp++; if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== {exp_inst, exp_inst, !exp_inst, !exp_inst}) begin
            n_fail++; $display("FAIL starve_oks%0d: got %b want %b", g,
               {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, {exp_inst, exp_inst, !exp_inst, !exp_inst}); end
         n_cmp++; if (dut.streak_q !== SW'(cnt)) begin n_fail++;
            $display("FAIL starve_streak%0d: got %0d want %0d", g, dut.streak_q, cnt); end
         if (g == 11) begin inst_req = 0; data_req = 0; end
         step();
         addr_ok = 0; data_ok = 0;
         #1;
         n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL starve_idle%0d: got %b want 0", g, busy); end
      end
      clear_inputs();
   endtask

   task automatic test_same_cycle();
      data_req = 1; data_wr = 0; data_size = 1; data_addr = 32'h8000_0042;
      step();
      addr_ok = 1; data_ok = 1; rdata = 32'hCAFE_F00D;
      #1;
      n_cmp++; if ({data_addr_ok, data_data_ok, inst_addr_ok, inst_data_ok, data_rdata} !== {4'b1100, 32'hCAFE_F00D}) begin
         n_fail++; $display("FAIL same_cycle_oks: got %h want %h",
            {data_addr_ok, data_data_ok, inst_addr_ok, inst_data_ok, data_rdata}, {4'b1100, 32'hCAFE_F00D}); end
      step();
      clear_inputs();
      #1;
      n_cmp++; if ({busy, req} !== 2'b00) begin n_fail++; $display("FAIL same_cycle_idle: got %b want 00", {busy, req}); end
   endtask

   task automatic test_reset_mid();
      inst_req = 1; inst_addr = 32'hBFC0_0200;
      step();
      addr_ok = 1;
      step();
      addr_ok = 0; inst_req = 0;
      #1;
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_wait: got %b want 1", busy); end
      resetn = 0;
      #1;
      n_cmp++; if ({busy, req} !== 2'b00) begin n_fail++; $display("FAIL rstmid_async: got %b want 00", {busy, req}); end
      step();
      resetn = 1;
      cnt = 0;
      step();
      data_ok = 1; rdata = 32'hDEAD_BEEF;
      #1;
      n_cmp++; if ({inst_data_ok, data_data_ok, busy} !== 3'b000) begin n_fail++;
         $display("FAIL rstmid_stray: got %b want 000", {inst_data_ok, data_data_ok, busy}); end
      step();
      clear_inputs();
   endtask

   task automatic test_random();
      logic        exp_inst, both;
      logic [66:0] exp_f;
      logic [31:0] rd;
      int          d1, d2;
      clear_inputs();
      step();
      for (int t = 0; t < 60; t++) begin
         if (!inst_req && !data_req) begin
            if ($urandom_range(0, 1) == 1) begin inst_req = 1; inst_addr = $urandom; end
            else begin
               data_req = 1; data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2));
               data_addr = $urandom; data_wdata = $urandom;
            end
         end
         exp_inst = inst_req && (!data_req || cnt == LIMIT);
         exp_f = exp_inst ? {1'b0, 2'd2, inst_addr, 32'd0} : {data_wr, data_size, data_addr, data_wdata};
         if (exp_inst) cnt = 0;
         else if (inst_req && cnt < LIMIT) cnt++;
         step();
         d1 = $urandom_range(0, 2);
         for (int k = 0; k < d1; k++) begin
            addr_ok = 0; data_ok = 1'($urandom);
            #1;
            n_cmp++; if ({req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b10000) begin n_fail++;
               $display("FAIL rand_addr_wait%0d: got %b want 10000", t,
                  {req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
            step();
         end
         both = ($urandom_range(0, 2) == 0);
         rd = $urandom;
         addr_ok = 1; data_ok = both; rdata = rd;
         #1;
         n_cmp++; if ({wr, size, addr, wdata} !== exp_f) begin n_fail++;
            $display("FAIL rand_fields%0d: got %h want %h", t, {wr, size, addr, wdata}, exp_f); end
         n_cmp++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !==
                      {exp_inst, !exp_inst, both && exp_inst, both && !exp_inst}) begin n_fail++;
            $display("FAIL rand_accept%0d: got %b want %b", t, {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
               {exp_inst, !exp_inst, both && exp_inst, both && !exp_inst}); end
         n_cmp++; if (dut.streak_q !== SW'(cnt)) begin n_fail++;
            $display("FAIL rand_streak%0d: got %0d want %0d", t, dut.streak_q, cnt); end
         step();
         addr_ok = 0; data_ok = 0;
         if (exp_inst) begin inst_req = 1'($urandom); inst_addr = $urandom; end
         else begin
            data_req = 1'($urandom); data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2));
            data_addr = $urandom; data_wdata = $urandom;
         end
         if (!both) begin
            d2 = $urandom_range(0, 2);
            for (int k = 0; k < d2; k++) begin
               #1;
               n_cmp++; if ({req, busy, inst_data_ok, data_data_ok} !== 4'b0100) begin n_fail++;
                  $display("FAIL rand_data_wait%0d: got %b want 0100", t, {req, busy, inst_data_ok, data_data_ok}); end
               step();
            end
            rd = $urandom;
            data_ok = 1; rdata = rd;
            #1;
            n_cmp++; if ({inst_data_ok, data_data_ok, (exp_inst ? inst_rdata : data_rdata)} !== {exp_inst, !exp_inst, rd}) begin
               n_fail++; $display("FAIL rand_done%0d: got %h want %h", t,
                  {inst_data_ok, data_data_ok, (exp_inst ? inst_rdata : data_rdata)}, {exp_inst, !exp_inst, rd}); end
            step();
            data_ok = 0;
         end
         #1;
         n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_idle%0d: got %b want 0", t, busy); end
      end
      clear_inputs();
      step();
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_store();
      test_simultaneous();
      test_starvation();
      test_same_cycle();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
